// File: rtl/rt_feed_pkg.sv
// Shared types and sizing helpers for the real-time sample feed.
package rt_feed_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PREFILL = 2'd1,
      STREAM  = 2'd2
   } feed_state_t;

   function automatic int samples_per_word(input int word_w, input int sample_w);
      return word_w / sample_w;
   endfunction

   // Occupancy needs one extra bit so a completely full FIFO reads as DEPTH.
   function automatic int fill_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rt_feed_fifo.sv
// Synchronous show-ahead word FIFO: head word is visible on rd_data whenever not empty.
module rt_feed_fifo
   import rt_feed_pkg::*;
#(
   parameter int WORD_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      push,
   input  logic [WORD_W-1:0]         wr_data,
   input  logic                      pop,
   output logic [WORD_W-1:0]         rd_data,
   output logic                      full,
   output logic                      empty,
   output logic [fill_w(DEPTH)-1:0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = fill_w(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count_q;
   logic              do_push;
   logic              do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign rd_data = mem[rd_ptr];
   assign count   = count_q;

   // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/rt_sample_feed.sv
// Real-time sample feed: buffers RX words, unpacks them into samples on strobe.
// Optional statistics counters are built when RT_SAMPLE_FEED_STATS_EN is defined.
module rt_sample_feed
   import rt_feed_pkg::*;
#(
   parameter int WORD_W      = 16,
   parameter int SAMPLE_W    = 2,
   parameter int DEPTH       = 256,
   parameter int START_LEVEL = 4,
   parameter int MSB_FIRST   = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      in_valid,
   input  logic [WORD_W-1:0]         in_data,
   output logic                      in_ready,
   input  logic                      sample_strobe,
   output logic [SAMPLE_W-1:0]       sample_out,
   output logic                      sample_valid,
   output logic                      streaming,
   output logic [fill_w(DEPTH)-1:0]  fill_level,
   output logic                      overflow,
   output logic                      underflow,
   input  logic                      clear_flags
`ifdef RT_SAMPLE_FEED_STATS_EN
   ,
   output logic [31:0]               words_in_count,
   output logic [15:0]               underflow_count
`endif
);

   localparam int SPW    = samples_per_word(WORD_W, SAMPLE_W);
   localparam int CNT_W  = $clog2(SPW + 1);
   localparam int FILL_W = fill_w(DEPTH);

   feed_state_t       state;
   logic [WORD_W-1:0] hold_q;
   logic [CNT_W-1:0]  hold_cnt;
   logic [WORD_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              strobe_act;
   logic              hold_has;
   logic              uflow_evt;
   logic              oflow_evt;

   function automatic logic [SAMPLE_W-1:0] first_sample(input logic [WORD_W-1:0] w);
      if (MSB_FIRST != 0) return w[WORD_W-1 -: SAMPLE_W];
      else                return w[SAMPLE_W-1:0];
   endfunction

   function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] w);
      if (MSB_FIRST != 0) return w << SAMPLE_W;
      else                return w >> SAMPLE_W;
   endfunction

   assign in_ready   = enable & ~fifo_full;
   assign push       = in_valid & in_ready;
   assign strobe_act = enable & sample_strobe & (state == STREAM);
   assign hold_has   = (hold_cnt != '0);
   assign pop        = strobe_act & ~hold_has & ~fifo_empty;
   assign uflow_evt  = strobe_act & ~hold_has & fifo_empty;
   assign oflow_evt  = enable & in_valid & fifo_full;
   assign streaming  = (state == STREAM);

   rt_feed_fifo #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .flush   (~enable),
      .push    (push),
      .wr_data (in_data),
      .pop     (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fill_level)
   );

   // Control, output sample register and sticky flags; a set event beats clear_flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         hold_cnt     <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         overflow     <= oflow_evt | (overflow & ~clear_flags);
         underflow    <= uflow_evt | (underflow & ~clear_flags);
         if (!enable) begin
            state    <= IDLE;
            hold_cnt <= '0;
         end else begin
            case (state)
               IDLE:    state <= PREFILL;
               PREFILL: if (fill_level >= FILL_W'(START_LEVEL)) state <= STREAM;
               STREAM: begin
                  if (sample_strobe) begin
                     sample_valid <= 1'b1;
                     if (hold_has) begin
                        sample_out <= first_sample(hold_q);
                        hold_cnt   <= hold_cnt - 1'b1;
                     end else if (!fifo_empty) begin
                        sample_out <= first_sample(fifo_head);
                        hold_cnt   <= CNT_W'(SPW - 1);
                     end else begin
                        sample_out <= '0;
                        state      <= PREFILL;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Holding register data path; only hold_cnt decides whether it is occupied.
   always_ff @(posedge clk) begin
      if (strobe_act) begin
         if (hold_has)        hold_q <= shift_word(hold_q);
         else if (!fifo_empty) hold_q <= shift_word(fifo_head);
      end
   end

`ifdef RT_SAMPLE_FEED_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         words_in_count  <= '0;
         underflow_count <= '0;
      end else if (clear_flags) begin
         words_in_count  <= {31'd0, push};
         underflow_count <= {15'd0, uflow_evt};
      end else begin
         if (push && (words_in_count != '1))       words_in_count  <= words_in_count + 1'b1;
         if (uflow_evt && (underflow_count != '1)) underflow_count <= underflow_count + 1'b1;
      end
   end
`endif

endmodule
